// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and select encodings for the
// multi-cycle MIPS-subset control FSM.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_R,
        CLS_I
    } alu_cls_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_EXT    = 2'b10;
    localparam logic [1:0] SRCB_EXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       PCWr;
        logic       PCWrCond;
        logic [1:0] PCSrc;
        logic       IRWr;
        logic       IorD;
        logic       MemRd;
        logic       MemWr;
        logic       MemtoReg;
        logic       RegWr;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ExtOp;
        logic [2:0] alu_ctrl;
        logic       retire;
        logic       illegal;
        logic       bus_err;
    } ctrl_out_t;

    function automatic logic is_wait(state_t s);
        return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: IR fields, memory handshake and
// datapath select bundle between controller and datapath.
interface multi_cycle_ctrl_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWr;
    logic       PCWrCond;
    logic [1:0] PCSrc;
    logic       IRWr;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       MemtoReg;
    logic       RegWr;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ExtOp;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  op, funct, zero, mem_ready,
        output PCWr, PCWrCond, PCSrc, IRWr, IorD,
        output MemRd, MemWr, MemtoReg, RegWr, RegDst,
        output ALUSrcA, ALUSrcB, ExtOp, alu_ctrl,
        output retire, illegal, bus_err
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  PCWr, PCWrCond, PCSrc, IRWr, IorD,
        input  MemRd, MemWr, MemtoReg, RegWr, RegDst,
        input  ALUSrcA, ALUSrcB, ExtOp, alu_ctrl,
        input  retire, illegal, bus_err
    );

endinterface

// File: rtl/multi_cycle_ctrl_alu_ctrl_dec.sv
// alu_ctrl_dec: maps the current state class plus op/funct
// to the ALU operation, and flags unsupported R-type functs.
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       bad_funct
);

    logic [2:0] r_alu;

    always_comb begin
        r_alu     = ALU_ADD;
        bad_funct = 1'b0;
        unique case (1'b1)
            funct == FN_ADDU: r_alu = ALU_ADD;
            funct == FN_SUBU: r_alu = ALU_SUB;
            funct == FN_AND:  r_alu = ALU_AND;
            funct == FN_OR:   r_alu = ALU_OR;
            funct == FN_SLT:  r_alu = ALU_SLT;
            default:          bad_funct = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (cls)
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_R:   alu_ctrl = r_alu;
            CLS_I:   alu_ctrl = (op == OP_ORI) ? ALU_OR : ALU_ADD;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: fetch/decode/execute/mem/writeback sequencer
// with a mem_ready wait-state timeout.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic              clk,
    input logic              rst_n,
    multi_cycle_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, cnt_n;
    logic [5:0]       op_q, funct_q;
    logic [5:0]       dec_op, dec_funct;
    alu_cls_t         cls;
    logic [2:0]       dec_alu;
    logic             bad_funct;
    logic             tmo_hit;
    ctrl_out_t        o, og;

    // DECODE must see the IR directly; later states use the latch.
    assign dec_op    = (state == S_DECODE) ? bus.op    : op_q;
    assign dec_funct = (state == S_DECODE) ? bus.funct : funct_q;
    assign tmo_hit   = (TIMEOUT != 0) && (wait_cnt == TMO_LAST);

    always_comb begin
        case (state)
            S_BRANCH: cls = CLS_SUB;
            S_R_EXEC: cls = CLS_R;
            S_I_EXEC: cls = CLS_I;
            default:  cls = CLS_ADD;
        endcase
    end

    alu_ctrl_dec u_alu_dec (
        .cls       (cls),
        .op        (dec_op),
        .funct     (dec_funct),
        .alu_ctrl  (dec_alu),
        .bad_funct (bad_funct)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
            funct_q  <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= cnt_n;
            if (state == S_DECODE) begin
                op_q    <= bus.op;
                funct_q <= bus.funct;
            end
        end
    end

    always_comb begin
        o          = '0;
        o.ExtOp    = EXT_SIGN;
        o.alu_ctrl = dec_alu;
        state_n    = state;
        case (state)
            S_FETCH: begin
                o.MemRd   = 1'b1;
                o.ALUSrcB = SRCB_FOUR;
                o.IRWr    = bus.mem_ready;
                o.PCWr    = bus.mem_ready;
                if (bus.mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                o.ALUSrcB = SRCB_EXT_SH;
                case (dec_op)
                    OP_LW, OP_SW:    state_n = S_MEM_ADDR;
                    OP_ADDIU, OP_ORI: state_n = S_I_EXEC;
                    OP_BEQ:          state_n = S_BRANCH;
                    OP_J:            state_n = S_JUMP;
                    OP_R: begin
                        o.illegal = bad_funct;
                        state_n   = bad_funct ? S_FETCH : S_R_EXEC;
                    end
                    default: begin
                        o.illegal = 1'b1;
                        state_n   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                o.ALUSrcA = 1'b1;
                o.ALUSrcB = SRCB_EXT;
                state_n   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                o.MemRd = 1'b1;
                o.IorD  = 1'b1;
                if (bus.mem_ready) state_n = S_MEM_WB;
            end
            S_MEM_WB: begin
                o.RegWr    = 1'b1;
                o.MemtoReg = 1'b1;
                o.retire   = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEM_WR: begin
                o.MemWr  = 1'b1;
                o.IorD   = 1'b1;
                o.retire = bus.mem_ready;
                if (bus.mem_ready) state_n = S_FETCH;
            end
            S_R_EXEC: begin
                o.ALUSrcA = 1'b1;
                o.ALUSrcB = SRCB_RT;
                state_n   = S_R_WB;
            end
            S_R_WB: begin
                o.RegWr  = 1'b1;
                o.RegDst = 1'b1;
                o.retire = 1'b1;
                state_n  = S_FETCH;
            end
            S_I_EXEC: begin
                o.ALUSrcA = 1'b1;
                o.ALUSrcB = SRCB_EXT;
                o.ExtOp   = (op_q == OP_ORI) ? EXT_ZERO : EXT_SIGN;
                state_n   = S_I_WB;
            end
            S_I_WB: begin
                o.RegWr  = 1'b1;
                o.retire = 1'b1;
                state_n  = S_FETCH;
            end
            S_BRANCH: begin
                o.ALUSrcA  = 1'b1;
                o.ALUSrcB  = SRCB_RT;
                o.PCWrCond = 1'b1;
                o.PCSrc    = PCSRC_ALUOUT;
                o.retire   = 1'b1;
                state_n    = S_FETCH;
            end
            S_JUMP: begin
                o.PCWr   = 1'b1;
                o.PCSrc  = PCSRC_JUMP;
                o.retire = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase

        cnt_n = (state_n != state) ? '0 : wait_cnt;
        if (is_wait(state) && !bus.mem_ready) begin
            if (tmo_hit) begin
                o.bus_err = 1'b1;
                state_n   = S_FETCH;
                cnt_n     = '0;
            end else begin
                cnt_n = wait_cnt + 1'b1;
            end
        end
    end

    assign og = rst_n ? o : '0;

    assign bus.PCWr     = og.PCWr;
    assign bus.PCWrCond = og.PCWrCond;
    assign bus.PCSrc    = og.PCSrc;
    assign bus.IRWr     = og.IRWr;
    assign bus.IorD     = og.IorD;
    assign bus.MemRd    = og.MemRd;
    assign bus.MemWr    = og.MemWr;
    assign bus.MemtoReg = og.MemtoReg;
    assign bus.RegWr    = og.RegWr;
    assign bus.RegDst   = og.RegDst;
    assign bus.ALUSrcA  = og.ALUSrcA;
    assign bus.ALUSrcB  = og.ALUSrcB;
    assign bus.ExtOp    = og.ExtOp;
    assign bus.alu_ctrl = og.alu_ctrl;
    assign bus.retire   = og.retire;
    assign bus.illegal  = og.illegal;
    assign bus.bus_err  = og.bus_err;

endmodule
